// File: rtl/ysyx_25040105_dmem.sv
// NPC data-memory responder: latched byte-lane load/store on a word array,
// answered after a fixed latency through a valid/ready response handshake.
module ysyx_25040105_dmem #(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_len,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam bit L1 = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] len_q, len_d;
  logic [31:0] wdata_q, wdata_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          c_wen;
  logic [31:0]   c_addr, c_len, c_wdata;
  logic [31:0]   rel;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          err;
  logic [3:0]    strb;
  logic [31:0]   lane;
  logic [31:0]   word;
  logic [31:0]   mask;
  logic [31:0]   ld;
  logic          commit;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign accept = req_valid && req_ready;

  // With LATENCY==1 the commit shares the accept edge, so use live inputs.
  always_comb begin
    c_wen   = wen_q;
    c_addr  = addr_q;
    c_len   = len_q;
    c_wdata = wdata_q;
    if (state_q == IDLE) begin
      c_wen   = req_wen;
      c_addr  = req_addr;
      c_len   = req_len;
      c_wdata = req_wdata;
    end
  end

  always_comb begin
    rel  = c_addr - ADDR_BASE;
    idx  = AW'(rel >> 2);
    off  = c_addr[1:0];
    err  = 1'b0;
    if (c_len != 32'd1 && c_len != 32'd2 && c_len != 32'd4) err = 1'b1;
    if (c_len == 32'd2 && off[0]) err = 1'b1;
    if (c_len == 32'd4 && off != 2'd0) err = 1'b1;
    if (c_addr < ADDR_BASE) err = 1'b1;
    if ({1'b0, rel} >= SPAN) err = 1'b1;
  end

  always_comb begin
    strb = 4'b1111;
    mask = 32'hffff_ffff;
    if (c_len == 32'd1) begin
      strb = 4'b0001 << off;
      mask = 32'h0000_00ff;
    end else if (c_len == 32'd2) begin
      strb = 4'b0011 << off;
      mask = 32'h0000_ffff;
    end
    lane = c_wdata << {off, 3'b000};
    word = mem[idx];
    ld   = (word >> {off, 3'b000}) & mask;
  end

  assign commit = rst_n &&
    ((state_q == IDLE && accept && L1) ||
     (state_q == WAIT && cnt_q == 4'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          len_d   = req_len;
          wdata_d = req_wdata;
          if (L1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = err;
      rdata_d = (err || c_wen) ? 32'd0 : ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Request latch and array are deliberately left out of reset.
  always_ff @(posedge clk) begin
    wen_q   <= wen_d;
    addr_q  <= addr_d;
    len_q   <= len_d;
    wdata_q <= wdata_d;
    for (int b = 0; b < 4; b++) begin
      if (commit && !err && c_wen && strb[b]) begin
        mem[idx][8*b +: 8] <= lane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_dmem.sv
// Bench for ysyx_25040105_dmem: three instances (latency 1, 4, 3) driven
// from a vector table and scoreboard, plus hold and reset sequences.
module tb_ysyx_25040105_dmem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv [3];
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_len;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic        rdy [3];
  logic        vld [3];
  logic [31:0] rdata [3];
  logic        rerr [3];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] len;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_25040105_dmem #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata[0]), .rsp_err(rerr[0])
  );

  ysyx_25040105_dmem #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata[1]), .rsp_err(rerr[1])
  );

  ysyx_25040105_dmem #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_ready(rsp_ready),
    .rsp_rdata(rdata[2]), .rsp_err(rerr[2])
  );

  function automatic int lat_of(int k);
    if (k == 0) return 1;
    if (k == 1) return 4;
    return 3;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic add(logic w, logic [31:0] a, logic [31:0] l,
                     logic [31:0] d, logic [31:0] er, logic ee,
                     string nm);
    vec_t v;
    v.wen = w; v.addr = a; v.len = l; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee; v.name = nm;
    tv.push_back(v);
  endtask

  // Entered and left on a negedge.
  task automatic run(int k, logic w, logic [31:0] a, logic [31:0] l,
                     logic [31:0] d, logic [31:0] er, logic ee,
                     int hold, string nm);
    exp_t e;
    exp_t got;
    int t;
    int lat;
    e.rdata = er;
    e.err = ee;
    sb.push_back(e);
    req_wen = w;
    req_addr = a;
    req_len = l;
    req_wdata = d;
    rv[k] = 1'b1;
    t = 0;
    while (!rdy[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy[k]) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      rv[k] = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(posedge clk);
    #1 rv[k] = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    lat = 1;
    @(negedge clk);
    while (!vld[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!vld[k]) begin
      chk({nm, "_rsp_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(lat_of(k)));
    chk({nm, "_ready_low"}, 32'(rdy[k]), 32'd0);
    got = sb.pop_front();
    chk({nm, "_rdata"}, rdata[k], got.rdata);
    chk({nm, "_err"}, 32'(rerr[k]), 32'(got.err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(vld[k]), 32'd1);
      chk({nm, "_hold_rdata"}, rdata[k], got.rdata);
      chk({nm, "_hold_ready"}, 32'(rdy[k]), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_back"}, 32'(rdy[k]), 32'd1);
    chk({nm, "_valid_drop"}, 32'(vld[k]), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) rv[k] = 1'b0;
    req_wen = 1'b0;
    req_addr = 32'h0;
    req_len = 32'd4;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy[k]), 32'd1);
      chk("rst_valid", 32'(vld[k]), 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
      chk("rst_err", 32'(rerr[k]), 32'd0);
    end

    add(1, 32'h8000_0000, 4, 32'h1122_3344, 32'h0, 0, "sw0");
    add(1, 32'h8000_0010, 4, 32'hDEAD_BEEF, 32'h0, 0, "sw10");
    add(0, 32'h8000_0010, 4, 32'h0, 32'hDEAD_BEEF, 0, "lw10");
    add(1, 32'h8000_0011, 1, 32'hFFFF_FF55, 32'h0, 0, "sb11");
    add(0, 32'h8000_0010, 4, 32'h0, 32'hDEAD_55EF, 0, "lw10b");
    add(0, 32'h8000_0012, 2, 32'h0, 32'h0000_DEAD, 0, "lhu12");
    add(0, 32'h8000_0011, 1, 32'h0, 32'h0000_0055, 0, "lbu11");
    add(0, 32'h8000_0002, 4, 32'h0, 32'h0, 1, "lw_mis");
    add(1, 32'h8000_0001, 2, 32'hFFFF, 32'h0, 1, "sh_mis");
    add(1, 32'h8000_0000, 3, 32'hFFFF_FFFF, 32'h0, 1, "len3");
    add(0, 32'h7FFF_FFFC, 4, 32'h0, 32'h0, 1, "lw_below");
    add(0, 32'h8000_0000, 4, 32'h0, 32'h1122_3344, 0, "lw0");
    add(1, 32'h8000_0FFC, 4, 32'hCAFE_F00D, 32'h0, 0, "sw_last");
    add(0, 32'h8000_0FFC, 4, 32'h0, 32'hCAFE_F00D, 0, "lw_last");
    add(0, 32'h8000_1000, 4, 32'h0, 32'h0, 1, "lw_end");
    add(1, 32'h8000_1000, 4, 32'h1, 32'h0, 1, "sw_end");
    add(0, 32'hFFFF_FFFC, 4, 32'h0, 32'h0, 1, "lw_top");
    add(0, 32'h8000_0000, 0, 32'h0, 32'h0, 1, "len0");
    add(0, 32'h8000_0000, 8, 32'h0, 32'h0, 1, "len8");
    add(1, 32'h8000_0002, 2, 32'h1234_BEEF, 32'h0, 0, "sh2");
    add(0, 32'h8000_0000, 4, 32'h0, 32'hBEEF_3344, 0, "lw0b");
    add(0, 32'h8000_0003, 1, 32'h0, 32'h0000_00BE, 0, "lbu3");
    add(0, 32'h8000_0000, 2, 32'h0, 32'h0000_3344, 0, "lhu0");

    foreach (tv[i]) begin
      run(0, tv[i].wen, tv[i].addr, tv[i].len, tv[i].wdata,
          tv[i].exp_rdata, tv[i].exp_err, 0, tv[i].name);
    end

    run(1, 1, 32'h8000_0040, 4, 32'h5A5A_A5A5, 32'h0, 0, 0, "l4_sw");
    run(1, 0, 32'h8000_0040, 4, 32'h0, 32'h5A5A_A5A5, 0, 3, "l4_lw");
    run(1, 0, 32'h8000_0041, 1, 32'h0, 32'h0000_00A5, 0, 1, "l4_lbu");

    run(2, 1, 32'h8000_0020, 4, 32'h0102_0304, 32'h0, 0, 0, "l3_sw");
    req_wen = 1'b1;
    req_addr = 32'h8000_0020;
    req_len = 32'd4;
    req_wdata = 32'h9999_9999;
    rv[2] = 1'b1;
    @(posedge clk);
    #1 rv[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("l3_in_wait", 32'(rdy[2]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(rdy[2]), 32'd1);
    chk("arst_valid", 32'(vld[2]), 32'd0);
    chk("arst_rdata", rdata[2], 32'd0);
    chk("arst_err", 32'(rerr[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("arst_no_rsp", 32'(vld[2]), 32'd0);
    end
    run(2, 0, 32'h8000_0020, 4, 32'h0, 32'h0102_0304, 0, 0, "l3_lw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
